// File: rtl/compress_est_pkg.sv
// compress_est shared types and helpers.
// Token cost functions for the LZ-style size estimator.
package compress_est_pkg;

    typedef enum logic [1:0] {
        MODE_RAW  = 2'd0,
        MODE_RLE  = 2'd1,
        MODE_DICT = 2'd2
    } mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int lit_cost(input int data_w);
        return 1 + data_w;
    endfunction

    function automatic int match_cost(input int idx_w, input int len_w);
        return 1 + idx_w + len_w;
    endfunction

endpackage

// File: rtl/compress_est_if.sv
// Streaming word input and window result bundle.
// The estimator takes the slave side.
interface compress_est_if #(
    parameter int DATA_W      = 32,
    parameter int WINDOW_LOG2 = 10,
    parameter int COUNT_W     = 21
);
    logic [DATA_W-1:0]    data;
    logic                 valid;
    logic [1:0]           mode;
    logic                 flush;
    logic [COUNT_W-1:0]   count;
    logic                 count_valid;
    logic [WINDOW_LOG2:0] words;
    logic                 saturated;

    modport master (
        output data, valid, mode, flush,
        input  count, count_valid, words, saturated
    );

    modport slave (
        input  data, valid, mode, flush,
        output count, count_valid, words, saturated
    );
endinterface

// File: rtl/compress_est_hist_match.sv
// History shift register with per-entry valid bits,
// parallel compare and lowest-index priority encoder.
module hist_match
    import compress_est_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int HIST_DEPTH = 8,
    parameter int IDX_W      = clog2(HIST_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     data,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic                  slot0_only,
    output logic [HIST_DEPTH-1:0] eq_vec,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);
    logic [DATA_W-1:0]     hist_q [HIST_DEPTH];
    logic [DATA_W-1:0]     hist_d [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hv_q;
    logic [HIST_DEPTH-1:0] hv_d;
    logic [HIST_DEPTH-1:0] srch;

    always_comb begin
        hist_d = hist_q;
        hv_d   = hv_q;
        if (shift_en) begin
            hist_d[0] = data;
            hv_d[0]   = 1'b1;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
                hv_d[i]   = hv_q[i-1];
            end
        end
        if (clear) hv_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) hv_q <= '0;
        else       hv_q <= hv_d;
    end

    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    always_comb begin
        eq_vec = '0;
        for (int i = 0; i < HIST_DEPTH; i++)
            eq_vec[i] = hv_q[i] && (hist_q[i] == data);
        srch = eq_vec;
        if (slot0_only)
            srch = {{(HIST_DEPTH-1){1'b0}}, eq_vec[0]};
        hit = |srch;
        idx = '0;
        for (int i = HIST_DEPTH - 1; i >= 0; i--)
            if (srch[i]) idx = IDX_W'(i);
    end

endmodule

// File: rtl/compress_est.sv
// Streaming compressed-size estimator: S1 input reg, S2 match
// and run decision, S3 accumulate, then registered window result.
module compress_est
    import compress_est_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int HIST_DEPTH  = 8,
    parameter int LEN_W       = 4,
    parameter int WINDOW_LOG2 = 10,
    parameter int COUNT_W     = 21
) (
    input  logic          clk,
    input  logic          reset,
    compress_est_if.slave bus
);
    localparam int IDX_W = clog2(HIST_DEPTH);
    localparam int ACC_W = COUNT_W + 1;
    localparam int CST_W = 16;
    localparam int SUM_W = ACC_W + CST_W;
    localparam int WC_W  = WINDOW_LOG2 + 1;

    localparam logic [CST_W-1:0] LIT_C = CST_W'(lit_cost(DATA_W));
    localparam logic [CST_W-1:0] MCH_C = CST_W'(match_cost(IDX_W, LEN_W));
    localparam logic [CST_W-1:0] RAW_C = CST_W'(DATA_W);
    localparam logic [LEN_W:0]   RUN_MAX = {1'b1, {LEN_W{1'b0}}};
    localparam logic [WC_W-1:0]  WIN_LEN = {1'b1, {WINDOW_LOG2{1'b0}}};
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {COUNT_W{1'b1}}};

    // S1
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_flush_q, s1_flush_d;
    logic [1:0]        s1_mode_q, s1_mode_d;

    // window, mode and run state
    logic [WC_W-1:0]   wcnt_q, wcnt_d, wcnt_inc;
    logic [1:0]        mode_q, mode_d, cur_mode;
    logic              run_act_q, run_act_d;
    logic [IDX_W-1:0]  run_off_q, run_off_d;
    logic [LEN_W:0]    run_len_q, run_len_d;
    logic              close, cont;

    // S2
    logic [CST_W-1:0]  s2_cost_q, s2_cost_d;
    logic              s2_close_q, s2_close_d;
    logic [WC_W-1:0]   s2_words_q, s2_words_d;

    // S3
    logic [ACC_W-1:0]  acc_q, acc_d, acc_n;
    logic              sat_q, sat_d, sat_n;
    logic [SUM_W-1:0]  sum;
    logic              clip;
    logic              s3_strobe_q, s3_strobe_d;
    logic [COUNT_W-1:0] s3_count_q, s3_count_d;
    logic              s3_sat_q, s3_sat_d;
    logic [WC_W-1:0]   s3_words_q, s3_words_d;

    // outputs
    logic [COUNT_W-1:0] count_q, count_d;
    logic               count_valid_q, count_valid_d;
    logic [WC_W-1:0]    words_q, words_d;
    logic               saturated_q, saturated_d;

    logic [HIST_DEPTH-1:0] eq_vec;
    logic                  hit;
    logic [IDX_W-1:0]      idx;

    hist_match #(
        .DATA_W     (DATA_W),
        .HIST_DEPTH (HIST_DEPTH),
        .IDX_W      (IDX_W)
    ) u_hist (
        .clk        (clk),
        .reset      (reset),
        .data       (s1_data_q),
        .shift_en   (s1_valid_q && !close),
        .clear      (close),
        .slot0_only (cur_mode == MODE_RLE),
        .eq_vec     (eq_vec),
        .hit        (hit),
        .idx        (idx)
    );

    always_comb begin
        s1_data_d  = bus.data;
        s1_valid_d = bus.valid;
        s1_flush_d = bus.flush;
        s1_mode_d  = bus.mode;
    end

    // The first word of a window latches the mode it is costed with.
    always_comb begin
        wcnt_inc  = wcnt_q + WC_W'(s1_valid_q);
        close     = (s1_valid_q && wcnt_inc == WIN_LEN)
                  || (s1_flush_q && wcnt_inc != '0);
        cur_mode  = (wcnt_q == '0) ? s1_mode_q : mode_q;
        cont      = run_act_q && eq_vec[run_off_q]
                  && run_len_q != RUN_MAX;
        wcnt_d    = wcnt_q;
        mode_d    = mode_q;
        run_act_d = run_act_q;
        run_off_d = run_off_q;
        run_len_d = run_len_q;
        s2_cost_d = '0;
        if (s1_valid_q) begin
            wcnt_d = wcnt_inc;
            if (wcnt_q == '0) mode_d = s1_mode_q;
            if (cur_mode == MODE_RAW) begin
                s2_cost_d = RAW_C;
                run_act_d = 1'b0;
            end else if (cont) begin
                run_len_d = run_len_q + (LEN_W+1)'(1);
            end else if (hit) begin
                s2_cost_d = MCH_C;
                run_act_d = 1'b1;
                run_off_d = idx;
                run_len_d = (LEN_W+1)'(1);
            end else begin
                s2_cost_d = LIT_C;
                run_act_d = 1'b0;
            end
        end
        if (close) begin
            wcnt_d    = '0;
            run_act_d = 1'b0;
            run_len_d = '0;
        end
        s2_close_d = close;
        s2_words_d = wcnt_inc;
    end

    always_comb begin
        sum   = SUM_W'(acc_q) + SUM_W'(s2_cost_q);
        clip  = sum > SUM_W'(ACC_MAX);
        acc_n = clip ? ACC_MAX : sum[ACC_W-1:0];
        sat_n = sat_q | clip;
        acc_d       = acc_n;
        sat_d       = sat_n;
        s3_strobe_d = 1'b0;
        s3_count_d  = s3_count_q;
        s3_sat_d    = s3_sat_q;
        s3_words_d  = s3_words_q;
        if (s2_close_q) begin
            s3_strobe_d = 1'b1;
            s3_count_d  = acc_n[COUNT_W-1:0];
            s3_sat_d    = sat_n;
            s3_words_d  = s2_words_q;
            acc_d       = '0;
            sat_d       = 1'b0;
        end
    end

    always_comb begin
        count_valid_d = s3_strobe_q;
        count_d       = count_q;
        words_d       = words_q;
        saturated_d   = saturated_q;
        if (s3_strobe_q) begin
            count_d     = s3_count_q;
            words_d     = s3_words_q;
            saturated_d = s3_sat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data_q     <= '0;
            s1_valid_q    <= 1'b0;
            s1_flush_q    <= 1'b0;
            s1_mode_q     <= '0;
            wcnt_q        <= '0;
            mode_q        <= '0;
            run_act_q     <= 1'b0;
            run_off_q     <= '0;
            run_len_q     <= '0;
            s2_cost_q     <= '0;
            s2_close_q    <= 1'b0;
            s2_words_q    <= '0;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            s3_strobe_q   <= 1'b0;
            s3_count_q    <= '0;
            s3_sat_q      <= 1'b0;
            s3_words_q    <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            words_q       <= '0;
            saturated_q   <= 1'b0;
        end else begin
            s1_data_q     <= s1_data_d;
            s1_valid_q    <= s1_valid_d;
            s1_flush_q    <= s1_flush_d;
            s1_mode_q     <= s1_mode_d;
            wcnt_q        <= wcnt_d;
            mode_q        <= mode_d;
            run_act_q     <= run_act_d;
            run_off_q     <= run_off_d;
            run_len_q     <= run_len_d;
            s2_cost_q     <= s2_cost_d;
            s2_close_q    <= s2_close_d;
            s2_words_q    <= s2_words_d;
            acc_q         <= acc_d;
            sat_q         <= sat_d;
            s3_strobe_q   <= s3_strobe_d;
            s3_count_q    <= s3_count_d;
            s3_sat_q      <= s3_sat_d;
            s3_words_q    <= s3_words_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            words_q       <= words_d;
            saturated_q   <= saturated_d;
        end
    end

    assign bus.count       = count_q;
    assign bus.count_valid = count_valid_q;
    assign bus.words       = words_q;
    assign bus.saturated   = saturated_q;

endmodule

// File: tb/tb_compress_est.sv
// Directed bench for compress_est: four instances share one
// stimulus stream, each checked on the windows it is sized for.
module tb_compress_est;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = '0;
    logic        valid = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        flush = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] A = 32'hDEAD_BEEF;
    localparam logic [31:0] B = 32'h1234_5678;

    always #5 clk = ~clk;

    compress_est_if #(.DATA_W(32), .WINDOW_LOG2(2), .COUNT_W(21)) b2 ();
    compress_est_if #(.DATA_W(32), .WINDOW_LOG2(5), .COUNT_W(21)) b5 ();
    compress_est_if #(.DATA_W(32), .WINDOW_LOG2(4), .COUNT_W(21)) b4 ();
    compress_est_if #(.DATA_W(32), .WINDOW_LOG2(4), .COUNT_W(8))  b8 ();

    assign b2.data = data;  assign b2.valid = valid;
    assign b2.mode = mode;  assign b2.flush = flush;
    assign b5.data = data;  assign b5.valid = valid;
    assign b5.mode = mode;  assign b5.flush = flush;
    assign b4.data = data;  assign b4.valid = valid;
    assign b4.mode = mode;  assign b4.flush = flush;
    assign b8.data = data;  assign b8.valid = valid;
    assign b8.mode = mode;  assign b8.flush = flush;

    compress_est #(
        .DATA_W(32), .HIST_DEPTH(8), .LEN_W(4),
        .WINDOW_LOG2(2), .COUNT_W(21)
    ) u2 (.clk(clk), .reset(reset), .bus(b2));

    compress_est #(
        .DATA_W(32), .HIST_DEPTH(8), .LEN_W(4),
        .WINDOW_LOG2(5), .COUNT_W(21)
    ) u5 (.clk(clk), .reset(reset), .bus(b5));

    compress_est #(
        .DATA_W(32), .HIST_DEPTH(8), .LEN_W(4),
        .WINDOW_LOG2(4), .COUNT_W(21)
    ) u4 (.clk(clk), .reset(reset), .bus(b4));

    compress_est #(
        .DATA_W(32), .HIST_DEPTH(8), .LEN_W(4),
        .WINDOW_LOG2(4), .COUNT_W(8)
    ) u8 (.clk(clk), .reset(reset), .bus(b8));

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample(input int sel, output logic cv,
                          output logic [31:0] cnt,
                          output logic [31:0] w, output logic s);
        case (sel)
            2: begin
                cv = b2.count_valid; cnt = 32'(b2.count);
                w = 32'(b2.words); s = b2.saturated;
            end
            5: begin
                cv = b5.count_valid; cnt = 32'(b5.count);
                w = 32'(b5.words); s = b5.saturated;
            end
            4: begin
                cv = b4.count_valid; cnt = 32'(b4.count);
                w = 32'(b4.words); s = b4.saturated;
            end
            default: begin
                cv = b8.count_valid; cnt = 32'(b8.count);
                w = 32'(b8.words); s = b8.saturated;
            end
        endcase
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] m,
                        input logic v, input logic f);
        @(negedge clk);
        data = d; mode = m; valid = v; flush = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Strobe must appear at the 4th negedge after the closing word is driven.
    task automatic expect_window(input int sel, input string tag,
                                 input int ecnt, input int ewords,
                                 input int esat);
        int lat;
        logic cv, s;
        logic [31:0] c, w;
        lat = 0;
        c = '0; w = '0; s = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            valid = 1'b0; flush = 1'b0;
            sample(sel, cv, c, w, s);
            if (cv) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, 4);
        check({tag, "_count"}, c, ecnt);
        check({tag, "_words"}, w, ewords);
        check({tag, "_sat"}, 32'(s), esat);
    endtask

    task automatic expect_quiet(input int sel, input string tag,
                                input int n);
        logic seen, cv, s;
        logic [31:0] c, w;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            valid = 1'b0; flush = 1'b0;
            sample(sel, cv, c, w, s);
            if (cv) seen = 1'b1;
        end
        check({tag, "_nostrobe"}, 32'(seen), 0);
    endtask

    initial begin
        logic cv, s;
        logic [31:0] c, w;

        repeat (3) @(negedge clk);
        sample(2, cv, c, w, s);
        check("rst_cv", 32'(cv), 0);
        check("rst_count", c, 0);
        check("rst_words", w, 0);
        check("rst_sat", 32'(s), 0);
        reset = 1'b0;

        // four repeats: literal + match + two continuations
        do_reset();
        repeat (4) send(A, 2'd2, 1'b1, 1'b0);
        expect_window(2, "aaaa", 41, 4, 0);

        // reset mid-window clears outputs and aborts the window
        repeat (3) send(A, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1; valid = 1'b0;
        @(negedge clk);
        sample(2, cv, c, w, s);
        check("midrst_count", c, 0);
        check("midrst_words", w, 0);
        reset = 1'b0;
        expect_quiet(2, "midrst", 8);
        repeat (4) send(A, 2'd2, 1'b1, 1'b0);
        expect_window(2, "after_rst", 41, 4, 0);

        // mode change mid-window is ignored
        do_reset();
        send(A, 2'd2, 1'b1, 1'b0);
        repeat (3) send(A, 2'd0, 1'b1, 1'b0);
        expect_window(2, "mode_latch", 41, 4, 0);

        do_reset();
        send(A, 2'd2, 1'b1, 1'b0); send(B, 2'd2, 1'b1, 1'b0);
        send(A, 2'd2, 1'b1, 1'b0); send(B, 2'd2, 1'b1, 1'b0);
        expect_window(2, "abab_dict", 74, 4, 0);

        do_reset();
        send(A, 2'd1, 1'b1, 1'b0); send(B, 2'd1, 1'b1, 1'b0);
        send(A, 2'd1, 1'b1, 1'b0); send(B, 2'd1, 1'b1, 1'b0);
        expect_window(2, "abab_rle", 132, 4, 0);

        do_reset();
        send(A, 2'd0, 1'b1, 1'b0); send(B, 2'd0, 1'b1, 1'b0);
        send(A, 2'd0, 1'b1, 1'b0); send(B, 2'd0, 1'b1, 1'b0);
        expect_window(2, "abab_raw", 128, 4, 0);

        do_reset();
        send(A, 2'd3, 1'b1, 1'b0); send(B, 2'd3, 1'b1, 1'b0);
        send(A, 2'd3, 1'b1, 1'b0); send(B, 2'd3, 1'b1, 1'b0);
        expect_window(2, "abab_m3", 74, 4, 0);

        // run capped at 16 words forces a second match token
        do_reset();
        repeat (32) send(A, 2'd2, 1'b1, 1'b0);
        expect_window(5, "run_cap", 49, 32, 0);

        // flush closes early; next window must start with empty history
        do_reset();
        send(A, 2'd2, 1'b1, 1'b0);
        send(A, 2'd2, 1'b1, 1'b1);
        expect_window(4, "flush1", 41, 2, 0);
        send(A, 2'd2, 1'b1, 1'b0);
        send(A, 2'd2, 1'b1, 1'b1);
        expect_window(4, "flush2", 41, 2, 0);
        send(32'd0, 2'd2, 1'b0, 1'b1);
        expect_quiet(4, "flush_empty", 8);

        // 16 raw words = 512 bits: clips at 8 bits, not at 21
        do_reset();
        for (int i = 0; i < 16; i++)
            send(32'(i * 7 + 1), 2'd0, 1'b1, 1'b0);
        expect_window(8, "sat8", 255, 16, 1);
        sample(4, cv, c, w, s);
        check("nosat21_cv", 32'(cv), 1);
        check("nosat21_count", c, 512);
        check("nosat21_sat", 32'(s), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/compress_est.md
# compress_est

Parametrised streaming compressed-size estimator for the capture path. It consumes one DATA_W-bit word per `valid` cycle and models an LZ-style tokeniser: literals, history matches and run extension. It accumulates the estimated compressed bit count over fixed windows of 2^WINDOW_LOG2 words, then reports each window result with a strobe. It generalises the fixed 32-bit / 21-bit compressor counter with configurable width, history depth, window length, mode select, flush and saturation.

## Interface
- DATA_W, 32: input word width (8..64)
- HIST_DEPTH, 8: history entries, power of 2 (2..64); IDX_W = log2(HIST_DEPTH)
- LEN_W, 4: run-length field width; max run per token = 2^LEN_W words
- WINDOW_LOG2, 10: window length = 2^WINDOW_LOG2 words
- COUNT_W, 21: result width
- Clock and reset (already decided): one clock, `clk`; reset is synchronous and active-high, port `reset`.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- data  in  DATA_W  input word
- valid  in  1  data qualifier; no backpressure, accepted every cycle
- mode  in  2  0 raw, 1 RLE (history slot 0 only), 2 dictionary, 3 same as 2
- flush  in  1  close current window early
- count  out  COUNT_W  estimated bits of last closed window; reset 0
- count_valid  out  1  one-cycle strobe when count updates; reset 0
- words  out  WINDOW_LOG2+1  words in last closed window; reset 0
- saturated  out  1  last window's count clipped; reset 0

## Operation
- Token costs:
  - literal = 1+DATA_W
  - match start = 1+IDX_W+LEN_W
  - run continuation = 0
  - mode 0: every word costs DATA_W; no history used
- History: shift register of the last HIST_DEPTH accepted words plus per-entry valid bits. Entry 0 is the most recent. All entries are invalidated at each window start, so windows are independent.
- Per word, in modes 1–3:
  - If a run is active at offset o, hist[o] is valid and equals data, and run_len < 2^LEN_W, then cost 0 and run_len++.
  - Otherwise search valid entries; mode 1 searches entry 0 only, modes 2/3 search all entries. On a hit, take the lowest hit index i, cost = match start, open a run at o=i with run_len=1. On a miss, cost = literal and no run.
  - The word is then shifted into the history.
- A run ends on a mismatch or on reaching 2^LEN_W; the next word is evaluated fresh in the same cycle.
- mode is latched at window start; changes mid-window are ignored until the next window.
- Accumulator is COUNT_W+1 bits; it clamps at 2^COUNT_W−1 and sets a sticky sat bit.
- Window closes when the 2^WINDOW_LOG2-th word is accepted, or on flush.
  - flush with valid in the same cycle: that word is included.
  - flush with zero words in the window: no strobe.
- On close: count, words and saturated are registered; count_valid pulses; the accumulator, run state, history and word counter are cleared.

## Timing
- Three-stage pipeline:
  - S1: input register.
  - S2: parallel compare and priority encode.
  - S3: cost add.
- Latency: count_valid rises 3 cycles after the edge that samples the closing word or flush.
- Back-to-back windows are supported at full rate, with no bubble between windows.
- Run-continuation state is forwarded S3→S2 so that consecutive valid words are handled correctly.
- Reset mid-window: pipeline, history and accumulator are cleared. No count_valid is produced for the aborted window. Outputs return to 0 on the next edge.
- valid low cycles are bubbles: no state changes other than the pipeline advance.

## Structure
- Package `compress_est_pkg`:
  - mode enum (MODE_RAW, MODE_RLE, MODE_DICT)
  - cost functions lit_cost(DATA_W) and match_cost(IDX_W, LEN_W)
  - clog2 helper
- One sub-module, `hist_match`: history shift register, valid bits, parallel compare and lowest-index priority encoder; outputs hit and idx.
- Top level holds the run state, accumulator, window counter and output registers.

## Test plan
Bench defaults: DATA_W=32, HIST_DEPTH=8, LEN_W=4, so literal=33 and match=8.
- WINDOW_LOG2=2, mode 2, words A,A,A,A → count=41, words=4, count_valid 3 cycles after the 4th word.
- WINDOW_LOG2=2, words A,B,A,B:
  - mode 2 → count=74
  - mode 1 → count=132
  - mode 0 → count=128
- WINDOW_LOG2=5, mode 2, 32× A → 33+8+8 = 49, because the run is capped at 16 words.
- WINDOW_LOG2=4, mode 2, A,A then flush with valid on the second word → count=41, words=2; the next window starts with empty history.
- COUNT_W=8, WINDOW_LOG2=4, mode 0, 16 words → count=255, saturated=1.
- reset after 3 of 4 words → no strobe; the following window A,A,A,A gives count=41.
